// File: rtl/uart_frame_loader.sv
// uart_frame_loader: arms the UART receiver, parses a 4-byte little-endian
// header (width, height), then streams W*H pixel bytes into the frame-buffer
// write port at sequential addresses starting at 0.
//
// Build option: define FRAME_CHECKSUM_EN to require one trailing byte equal to
// the XOR of all header and pixel bytes; a mismatch raises o_Error.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | receiver disarmed, waiting for i_Start
// HDR    | collecting W[7:0], W[15:8], H[7:0], H[15:8]
// PIXELS | writing one pixel per received byte until index N-1
// CHECK  | (FRAME_CHECKSUM_EN) waiting for the trailing checksum byte
// FIN    | one-cycle o_Done, then back to IDLE
module uart_frame_loader #(
  parameter int ADDR_W     = 15,
  parameter int MAX_PIXELS = 19200
) (
  input  logic              i_Clock,
  input  logic              reset,
  input  logic              i_Start,
  output logic              o_Receive,
  input  logic              i_Rx_DV,
  input  logic [7:0]        i_Rx_Byte,
  output logic              o_Mem_We,
  output logic [ADDR_W-1:0] o_Mem_Addr,
  output logic [7:0]        o_Mem_Data,
  output logic [15:0]       o_Width,
  output logic [15:0]       o_Height,
  output logic              o_Busy,
  output logic              o_Done,
  output logic              o_Error
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_HDR    = 3'd1;
  localparam logic [2:0] S_PIXELS = 3'd2;
`ifdef FRAME_CHECKSUM_EN
  localparam logic [2:0] S_CHECK  = 3'd3;
`endif
  localparam logic [2:0] S_FIN    = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [15:0]       hdr_w_q, hdr_w_d;
  logic [7:0]        hdr_h_lo_q, hdr_h_lo_d;
  logic [31:0]       npix_q, npix_d;
  logic [ADDR_W-1:0] pix_idx_q, pix_idx_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        data_q, data_d;
  logic              error_q, error_d;
  logic [15:0]       width_q, width_d;
  logic [15:0]       height_q, height_d;
  logic [7:0]        ck_q, ck_d;

  logic [15:0] h_full;
  logic [31:0] n_calc;
  logic        hdr_bad;
  logic        last_pix;

  // Header arithmetic on the 4th byte: full 32-bit product so oversize
  // frames can never alias into an accepted size.
  always_comb begin
    h_full   = {i_Rx_Byte, hdr_h_lo_q};
    n_calc   = {16'd0, hdr_w_q} * {16'd0, h_full};
    hdr_bad  = (hdr_w_q == 16'd0) || (h_full == 16'd0) ||
               (n_calc > $unsigned(MAX_PIXELS));
    last_pix = ({{(32-ADDR_W){1'b0}}, pix_idx_q} == (npix_q - 32'd1));
  end

  // Next-state and datapath logic for the whole loader.
  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    hdr_w_d    = hdr_w_q;
    hdr_h_lo_d = hdr_h_lo_q;
    npix_d     = npix_q;
    pix_idx_d  = pix_idx_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    data_d     = data_q;
    error_d    = error_q;
    width_d    = width_q;
    height_d   = height_q;
    ck_d       = ck_q;

    case (state_q)
      S_IDLE: begin
        if (i_Start) begin
          state_d    = S_HDR;
          error_d    = 1'b0;
          byte_cnt_d = 2'd0;
          pix_idx_d  = '0;
          ck_d       = 8'd0;
        end
      end
      S_HDR: begin
        if (i_Rx_DV) begin
          ck_d       = ck_q ^ i_Rx_Byte;
          byte_cnt_d = byte_cnt_q + 2'd1;
          case (byte_cnt_q)
            2'd0: hdr_w_d[7:0]  = i_Rx_Byte;
            2'd1: hdr_w_d[15:8] = i_Rx_Byte;
            2'd2: hdr_h_lo_d    = i_Rx_Byte;
            default: begin
              width_d  = hdr_w_q;
              height_d = h_full;
              npix_d   = n_calc;
              if (hdr_bad) begin
                error_d = 1'b1;
                state_d = S_FIN;
              end else begin
                state_d = S_PIXELS;
              end
            end
          endcase
        end
      end
      S_PIXELS: begin
        if (i_Rx_DV) begin
          we_d      = 1'b1;
          addr_d    = pix_idx_q;
          data_d    = i_Rx_Byte;
          pix_idx_d = pix_idx_q + 1'b1;
          ck_d      = ck_q ^ i_Rx_Byte;
          if (last_pix) begin
`ifdef FRAME_CHECKSUM_EN
            state_d = S_CHECK;
`else
            state_d = S_FIN;
`endif
          end
        end
      end
`ifdef FRAME_CHECKSUM_EN
      S_CHECK: begin
        if (i_Rx_DV) begin
          if (i_Rx_Byte != ck_q) error_d = 1'b1;
          state_d = S_FIN;
        end
      end
`endif
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset abandons any frame in progress.
  always_ff @(posedge i_Clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      byte_cnt_q <= 2'd0;
      hdr_w_q    <= 16'd0;
      hdr_h_lo_q <= 8'd0;
      npix_q     <= 32'd0;
      pix_idx_q  <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      data_q     <= 8'd0;
      error_q    <= 1'b0;
      width_q    <= 16'd0;
      height_q   <= 16'd0;
      ck_q       <= 8'd0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      hdr_w_q    <= hdr_w_d;
      hdr_h_lo_q <= hdr_h_lo_d;
      npix_q     <= npix_d;
      pix_idx_q  <= pix_idx_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      error_q    <= error_d;
      width_q    <= width_d;
      height_q   <= height_d;
      ck_q       <= ck_d;
    end
  end

  // Status outputs decode straight from the state register.
  always_comb begin
    o_Busy    = (state_q != S_IDLE);
    o_Done    = (state_q == S_FIN);
    o_Receive = (state_q == S_HDR) || (state_q == S_PIXELS)
`ifdef FRAME_CHECKSUM_EN
                || (state_q == S_CHECK)
`endif
                ;
  end

  assign o_Mem_We   = we_q;
  assign o_Mem_Addr = addr_q;
  assign o_Mem_Data = data_q;
  assign o_Width    = width_q;
  assign o_Height   = height_q;
  assign o_Error    = error_q;

endmodule
